rf_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback sources:
//  A (single-cycle ALU) and M (multi-cycle load/mul unit).

---
 rtl/rf_pkg.sv | 22 ++
 rtl/rf_scoreboard.sv | 50 +++++
 rtl/rf_wb_arbiter.sv | 93 +++++++++
 tb/tb_rf_wb_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared widths and types for the register-file writeback path.
//   XLEN       register data width
//   AW         register address width (NREGS = 2**AW, x0 hardwired zero)
//   reg_addr_t register index
//   word_t     register data word
//   wb_req_t   one writeback request (valid + destination + data)
package rf_pkg;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NREGS = 2 ** AW;

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] word_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
        word_t     data;
    } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write bits for decode stall checks.
//   CLK, RSTn          clock, synchronous active-low reset
//   set_en, set_addr   issued instruction claims a destination register
//   clr_en, clr_addr   RF write retiring that destination on this edge
//   ra1, ra2           decode source queries
//   busy1, busy2       pending bit of ra1/ra2 (pure lookup of current state)
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic      CLK,
    input  logic      RSTn,
    input  logic      set_en,
    input  reg_addr_t set_addr,
    input  logic      clr_en,
    input  reg_addr_t clr_addr,
    input  reg_addr_t ra1,
    input  reg_addr_t ra2,
    output logic      busy1,
    output logic      busy2
);

    logic [NREGS-1:0] busy;

    // x0 is never a real destination, so its bit stays low forever.
    always_ff @(posedge CLK) begin
        busy[0] <= 1'b0;
    end

    genvar i;
    generate
        for (i = 1; i < NREGS; i++) begin : g_bit
            logic set_hit;
            logic clr_hit;
            assign set_hit = set_en && (set_addr == reg_addr_t'(i));
            assign clr_hit = clr_en && (clr_addr == reg_addr_t'(i));

            // A set on the retire edge means a newer producer is in flight,
            // so it takes precedence over the clear.
            always_ff @(posedge CLK) begin
                if (!RSTn)        busy[i] <= 1'b0;
                else if (set_hit) busy[i] <= 1'b1;
                else if (clr_hit) busy[i] <= 1'b0;
            end
        end
    endgenerate

    assign busy1 = busy[ra1];
    assign busy2 = busy[ra2];

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single RF write port between the ALU (A) and the
// load/mul unit (M), registers the winning write, and tracks pending
// destinations for decode.
//   CLK, RSTn                      clock, synchronous active-low reset
//   a_valid/a_ready/a_addr/a_data  ALU writeback handshake
//   m_valid/m_ready/m_addr/m_data  load/mul writeback handshake
//   iss_valid, iss_rd              issued instruction destination
//   RA1, RA2 -> busy1, busy2       decode pending-write queries
//   WE, WA, WD3                    registered RF write port
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic      CLK,
    input  logic      RSTn,
    input  logic      a_valid,
    output logic      a_ready,
    input  reg_addr_t a_addr,
    input  word_t     a_data,
    input  logic      m_valid,
    output logic      m_ready,
    input  reg_addr_t m_addr,
    input  word_t     m_data,
    input  logic      iss_valid,
    input  reg_addr_t iss_rd,
    input  reg_addr_t RA1,
    input  reg_addr_t RA2,
    output logic      busy1,
    output logic      busy2,
    output logic      WE,
    output reg_addr_t WA,
    output word_t     WD3
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;
    logic          a_win;
    wb_req_t       win;

    // M has priority unless A is alone or has waited long enough.
    assign starved = (starve_cnt == CW'(STARVE_MAX));
    assign a_win   = a_valid && (!m_valid || starved);
    assign a_ready = RSTn && a_win;
    assign m_ready = RSTn && m_valid && !a_win;

    always_comb begin
        win = '0;
        if (a_ready) begin
            win.valid = 1'b1;
            win.addr  = a_addr;
            win.data  = a_data;
        end else if (m_ready) begin
            win.valid = 1'b1;
            win.addr  = m_addr;
            win.data  = m_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            WE         <= 1'b0;
            WA         <= '0;
            WD3        <= '0;
            starve_cnt <= '0;
        end else begin
            // x0 writes are consumed here but never reach the RF.
            WE <= win.valid && (win.addr != '0);
            if (win.valid) begin
                WA  <= win.addr;
                WD3 <= win.data;
            end
            if (!a_valid || a_ready) starve_cnt <= '0;
            else if (!starved)       starve_cnt <= starve_cnt + 1'b1;
        end
    end

    rf_scoreboard u_sb (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .set_en   (iss_valid),
        .set_addr (iss_rd),
        .clr_en   (WE),
        .clr_addr (WA),
        .ra1      (RA1),
        .ra2      (RA2),
        .busy1    (busy1),
        .busy2    (busy2)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int SM = 3;

    logic      CLK = 1'b0;
    logic      RSTn = 1'b0;
    logic      a_valid = 1'b1, m_valid = 1'b1, iss_valid = 1'b0;
    reg_addr_t a_addr = '0, m_addr = '0, iss_rd = '0, RA1 = '0, RA2 = '0;
    word_t     a_data = '0, m_data = '0;
    logic      a_ready, m_ready, busy1, busy2, WE;
    reg_addr_t WA;
    word_t     WD3;

    always #5 CLK = ~CLK;

    rf_wb_arbiter #(.STARVE_MAX(SM)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .RA1(RA1), .RA2(RA2),
        .busy1(busy1), .busy2(busy2), .WE(WE), .WA(WA), .WD3(WD3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int    waited = 0;            // consecutive cycles A has been refused
    bit    exp_we = 1'b0;
    reg_addr_t exp_wa = '0;
    word_t exp_wd = '0;
    bit    pend [NREGS];
    word_t rf_exp [NREGS];
    word_t rf_dut [NREGS];
    bit    started = 1'b0;

    initial begin
        for (int r = 0; r < NREGS; r++) begin
            pend[r] = 1'b0; rf_exp[r] = '0; rf_dut[r] = '0;
        end
    end

    // A is served when it is alone or has been refused SM times in a row.
    function automatic logic grant_a();
        return RSTn && a_valid && (!m_valid || waited >= SM);
    endfunction
    function automatic logic grant_m();
        return RSTn && m_valid && !grant_a();
    endfunction

    always @(posedge CLK) begin
        logic ga, gm;
        ga = grant_a();
        gm = grant_m();
        if (!RSTn) begin
            waited = 0; exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
            for (int r = 0; r < NREGS; r++) pend[r] = 1'b0;
        end else begin
            if (exp_we) pend[exp_wa] = 1'b0;
            if (iss_valid && iss_rd != 0) pend[iss_rd] = 1'b1;
            if (ga) begin
                exp_we = (a_addr != 0); exp_wa = a_addr; exp_wd = a_data;
                if (a_addr != 0) rf_exp[a_addr] = a_data;
            end else if (gm) begin
                exp_we = (m_addr != 0); exp_wa = m_addr; exp_wd = m_data;
                if (m_addr != 0) rf_exp[m_addr] = m_data;
            end else begin
                exp_we = 1'b0;
            end
            if (!a_valid || ga) waited = 0;
            else if (waited < SM) waited++;
        end
        started = 1'b1;
    end

    always @(negedge CLK) begin
        if (started) begin
            chk("a_ready", 32'(a_ready), 32'(grant_a()));
            chk("m_ready", 32'(m_ready), 32'(grant_m()));
            chk("WE", 32'(WE), 32'(exp_we));
            chk("WA", 32'(WA), 32'(exp_wa));
            chk("WD3", WD3, exp_wd);
            chk("busy1", 32'(busy1), 32'(pend[RA1]));
            chk("busy2", 32'(busy2), 32'(pend[RA2]));
            chk("dual_grant", 32'(a_ready && m_ready), 32'd0);
            chk("we_x0", 32'(WE && (WA == '0)), 32'd0);
            if (WE) rf_dut[WA] = WD3;
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [4:0] a_grant_pat;
        a_grant_pat = 5'b01000;

        // 1: reset held with both requesters valid
        cyc(); cyc();
        #2;
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_m_ready", 32'(m_ready), 32'd0);
        chk("rst_WE", 32'(WE), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_busy2", 32'(busy2), 32'd0);
        cyc();
        RSTn = 1'b1; a_valid = 1'b0; m_valid = 1'b0;

        // 2: single A write
        cyc();
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        #2 chk("t2_a_ready", 32'(a_ready), 32'd1);
        cyc();
        a_valid = 1'b0;
        #2;
        chk("t2_WE", 32'(WE), 32'd1);
        chk("t2_WA", 32'(WA), 32'd5);
        chk("t2_WD3", WD3, 32'hDEADBEEF);
        cyc();
        #2 chk("t2_WE_low", 32'(WE), 32'd0);

        // 3: sustained contention, A starves for 3 cycles then wins once
        cyc();
        a_valid = 1'b1; m_valid = 1'b1; a_addr = 5'd4; m_addr = 5'd3;
        a_data = 32'hAAAA0004; m_data = 32'hBBBB0003;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("t3_a_ready", 32'(a_ready), 32'(a_grant_pat[k]));
            chk("t3_m_ready", 32'(m_ready), 32'(!a_grant_pat[k]));
            cyc();
        end
        a_valid = 1'b0; m_valid = 1'b0;

        // 4: write to x0 is consumed without WE
        cyc();
        m_valid = 1'b1; m_addr = 5'd0; m_data = 32'h1234;
        #2 chk("t4_m_ready", 32'(m_ready), 32'd1);
        cyc();
        m_valid = 1'b0;
        #2 chk("t4_WE", 32'(WE), 32'd0);

        // 5: scoreboard set / clear / set-wins-over-clear
        cyc();
        iss_valid = 1'b1; iss_rd = 5'd7; RA1 = 5'd7;
        #2 chk("t5_busy_pre", 32'(busy1), 32'd0);
        cyc();
        iss_valid = 1'b0; m_valid = 1'b1; m_addr = 5'd7; m_data = 32'h77;
        #2 chk("t5_busy_set", 32'(busy1), 32'd1);
        cyc();
        m_valid = 1'b0;
        #2;
        chk("t5_WE", 32'(WE), 32'd1);
        chk("t5_busy_during_we", 32'(busy1), 32'd1);
        cyc();
        #2 chk("t5_busy_clr", 32'(busy1), 32'd0);
        m_valid = 1'b1; m_addr = 5'd7; m_data = 32'h78;
        cyc();
        m_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd7;
        #2 chk("t5_WE2", 32'(WE), 32'd1);
        cyc();
        iss_valid = 1'b0;
        #2 chk("t5_busy_reissue", 32'(busy1), 32'd1);

        // 6: random mix, with one reset pulse in the middle
        for (int i = 0; i < 2000; i++) begin
            cyc();
            RSTn      = (i != 1000);
            a_valid   = 1'($urandom_range(0, 1));
            m_valid   = 1'($urandom_range(0, 1));
            a_addr    = reg_addr_t'($urandom_range(0, 7));
            m_addr    = reg_addr_t'($urandom_range(0, 7));
            a_data    = $urandom;
            m_data    = $urandom;
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd    = reg_addr_t'($urandom_range(0, 7));
            RA1       = reg_addr_t'($urandom_range(0, 7));
            RA2       = reg_addr_t'($urandom_range(0, NREGS - 1));
        end
        cyc();
        a_valid = 1'b0; m_valid = 1'b0; iss_valid = 1'b0;
        cyc(); cyc(); cyc();
        for (int r = 1; r < NREGS; r++) chk("rf_contents", rf_dut[r], rf_exp[r]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
